// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//
// Builds a 32-bit RV32 instruction word from its separate fields: opcode,
// register numbers, funct3/funct7 and a sign-extended 32-bit immediate.
// It is the inverse of the immediate generator. When imm_err is 0, decoding
// inst_code gives back exactly the imm that went in.
//
// Encoding is combinational. The result goes into a one-entry output
// register that uses a valid/ready handshake on both sides. A byte-address
// counter follows the accepted words, so a memory writer can use
// inst_addr/inst_code directly as its write port.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   clear      in   1       synchronous flush: empty, address to BASE_ADDR,
//                           error count to 0
//   in_valid   in   1       field bundle valid
//   in_ready   out  1       encoder can accept a bundle
//   opcode     in   7       inst[6:0]
//   rd         in   5       destination register (R/I/U)
//   funct3     in   3       funct3 (R/I/S/B)
//   rs1        in   5       source register 1 (R/I/S/B)
//   rs2        in   5       source register 2 (R/S/B)
//   funct7     in   7       funct7 (R only)
//   imm        in   32      sign-extended immediate
//   out_valid  out  1       inst_code/inst_addr/imm_err valid
//   out_ready  in   1       consumer takes the word
//   inst_code  out  32      encoded instruction
//   inst_addr  out  ADDR_W  byte address of inst_code
//   imm_err    out  1       imm did not fit; inst_code holds truncated field
//   err_cnt    out  8       saturating count of delivered words with imm_err
// ---------------------------------------------------------------------------
module inst_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [2:0]        funct3,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       inst_code,
   output logic [ADDR_W-1:0] inst_addr,
   output logic              imm_err,
   output logic [7:0]        err_cnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [31:0] NOP_WORD = 32'h00000013;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       code_q, code_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        cnt_q, cnt_d;

   logic [31:0] enc_code;
   logic        enc_err;
   logic        in_hs;
   logic        out_hs;
   logic        hi11_ok;
   logic        hi12_ok;

   // The immediate fits in a 12-bit signed field only if bits 31..11 are
   // all the same sign. Branch offsets are 13 bits, so there the check
   // starts at bit 12.
   assign hi11_ok = (&imm[31:11]) | ~(|imm[31:11]);
   assign hi12_ok = (&imm[31:12]) | ~(|imm[31:12]);

   // Combinational field packing. Each format selects only the fields it
   // owns, so values on unused inputs never reach the word. Unknown opcodes
   // produce a NOP and are flagged, so a bad program image is visible.
   always_comb begin
      enc_code = NOP_WORD;
      enc_err  = 1'b1;
      case (opcode)
         OP_LOAD, OP_IMM: begin
            enc_code = {imm[11:0], rs1, funct3, rd, opcode};
            enc_err  = ~hi11_ok;
         end
         OP_STORE: begin
            enc_code = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            enc_err  = ~hi11_ok;
         end
         OP_LUI: begin
            enc_code = {imm[31:12], rd, opcode};
            enc_err  = |imm[11:0];
         end
         OP_BRANCH: begin
            enc_code = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            enc_err  = imm[0] | ~hi12_ok;
         end
         OP_REG: begin
            enc_code = {funct7, rs2, rs1, funct3, rd, opcode};
            enc_err  = 1'b0;
         end
         default: begin
            enc_code = NOP_WORD;
            enc_err  = 1'b1;
         end
      endcase
   end

   // The skid-free output stage can take a new word while the current one
   // leaves, which gives one word per clock when the consumer is ready.
   assign in_ready  = (state_q == EMPTY) | out_ready;
   assign in_hs     = in_valid & in_ready;
   assign out_valid = (state_q == FULL);
   assign out_hs    = out_valid & out_ready;

   // Next-state logic for the output register, address counter and error
   // counter. clear takes priority over any handshake in the same cycle, so
   // a word that arrives during clear is dropped. The address moves forward
   // only when a word leaves, so inst_addr always belongs to the word now on
   // inst_code.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      err_d   = err_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = EMPTY;
         code_d  = '0;
         err_d   = 1'b0;
         addr_d  = BASE_ADDR;
         cnt_d   = '0;
      end else begin
         if (out_hs) begin
            addr_d = addr_q + ADDR_W'(4);
            if (err_q && (cnt_q != 8'hFF)) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         if (in_hs) begin
            state_d = FULL;
            code_d  = enc_code;
            err_d   = enc_err;
         end else if (out_hs) begin
            state_d = EMPTY;
         end
      end
   end

   // State register. An asynchronous reset throws away any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         code_q  <= '0;
         err_q   <= 1'b0;
         addr_q  <= BASE_ADDR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign inst_code = code_q;
   assign imm_err   = err_q;
   assign inst_addr = addr_q;
   assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
//
// Directed testbench for inst_encoder. It drives one linear sequence of
// field bundles. Each expected word was worked out by hand from the RV32
// formats. A second instance with its base address near the top of the
// address space shares the same inputs and shows the address wrap.
// ---------------------------------------------------------------------------
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] inst_code;
   logic [31:0] inst_addr;
   logic        imm_err;
   logic [7:0]  err_cnt;

   logic        inReady2;
   logic        outValid2;
   logic [31:0] instCode2;
   logic [31:0] instAddr2;
   logic        immErr2;
   logic [7:0]  errCnt2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
      .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .inst_code(inst_code), .inst_addr(inst_addr),
      .imm_err(imm_err), .err_cnt(err_cnt)
   );

   inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'hFFFFFFFC)) dutWrap (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(inReady2),
      .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
      .funct7(funct7), .imm(imm),
      .out_valid(outValid2), .out_ready(out_ready),
      .inst_code(instCode2), .inst_addr(instAddr2),
      .imm_err(immErr2), .err_cnt(errCnt2)
   );

   // One comparison: count it. On a mismatch, count the failure and report
   // the tag with the observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Put a field bundle on the input and mark it valid.
   task automatic applyStimulus(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                                input logic [31:0] im);
      opcode   = op;
      rd       = d;
      funct3   = f3;
      rs1      = s1;
      rs2      = s2;
      funct7   = f7;
      imm      = im;
      in_valid = 1'b1;
   endtask

   // Move one clock forward and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the whole visible word in one call.
   task automatic checkWord(input string tag, input logic [31:0] code, input logic err,
                            input logic [31:0] addr, input logic [7:0] cnt);
      checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, ".code"}, inst_code, code);
      checkOutput({tag, ".err"}, 32'(imm_err), 32'(err));
      checkOutput({tag, ".addr"}, inst_addr, addr);
      checkOutput({tag, ".cnt"}, 32'(err_cnt), 32'(cnt));
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      opcode    = '0;
      rd        = '0;
      funct3    = '0;
      rs1       = '0;
      rs2       = '0;
      funct7    = '0;
      imm       = '0;

      // Reset state
      #12;
      checkOutput("rst.valid", 32'(out_valid), 32'd0);
      checkOutput("rst.code", inst_code, 32'h0);
      checkOutput("rst.err", 32'(imm_err), 32'd0);
      checkOutput("rst.addr", inst_addr, 32'h0);
      checkOutput("rst.cnt", 32'(err_cnt), 32'd0);
      checkOutput("rst.ready", 32'(in_ready), 32'd1);
      checkOutput("rst.wrapAddr", instAddr2, 32'hFFFFFFFC);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back stream with out_ready high. Junk values on unused fields must not leak.
      applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'h1F, 7'h7F, 32'hFFFFFFFF);
      step();
      checkWord("addi", 32'hFFF00093, 1'b0, 32'h0, 8'd0);
      checkOutput("addi.wrapAddr", instAddr2, 32'hFFFFFFFC);

      applyStimulus(7'b0100011, 5'h1F, 3'd2, 5'd0, 5'd2, 7'h7F, 32'h00000008);
      step();
      checkWord("sw", 32'h00202423, 1'b0, 32'h4, 8'd0);
      checkOutput("sw.wrapAddr", instAddr2, 32'h0);

      applyStimulus(7'b1100011, 5'h1F, 3'd0, 5'd0, 5'd0, 7'h7F, 32'hFFFFFFFC);
      step();
      checkWord("beq", 32'hFE000EE3, 1'b0, 32'h8, 8'd0);

      applyStimulus(7'b0110111, 5'd5, 3'd7, 5'h1F, 5'h1F, 7'h7F, 32'h12345000);
      step();
      checkWord("lui", 32'h123452B7, 1'b0, 32'hC, 8'd0);

      applyStimulus(7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'h0, 32'h12345001);
      step();
      checkWord("luiErr", 32'h123452B7, 1'b1, 32'h10, 8'd0);

      applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'h00000800);
      step();
      checkWord("addiErr", 32'h80000093, 1'b1, 32'h14, 8'd1);

      applyStimulus(7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h00000003);
      step();
      checkWord("bOdd", 32'h00000163, 1'b1, 32'h18, 8'd2);

      applyStimulus(7'h7F, 5'd3, 3'd1, 5'd1, 5'd2, 7'h20, 32'h0);
      step();
      checkWord("badOp", 32'h00000013, 1'b1, 32'h1C, 8'd3);

      applyStimulus(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'hFFFFFFFF);
      step();
      checkWord("add", 32'h002081B3, 1'b0, 32'h20, 8'd4);

      applyStimulus(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'h0);
      step();
      checkWord("sub", 32'h402081B3, 1'b0, 32'h24, 8'd4);

      in_valid = 1'b0;
      step();
      checkOutput("drain.valid", 32'(out_valid), 32'd0);
      checkOutput("drain.addr", inst_addr, 32'h28);
      checkOutput("drain.cnt", 32'(err_cnt), 32'd4);

      // Stall: the consumer holds off for three clocks while the producer waits with the next word
      out_ready = 1'b0;
      applyStimulus(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'h0, 32'd1);
      step();
      applyStimulus(7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2);
      for (int i = 0; i < 3; i++) begin
         checkWord("stall", 32'h00100113, 1'b0, 32'h28, 8'd4);
         checkOutput("stall.ready", 32'(in_ready), 32'd0);
         step();
      end
      checkWord("stallEnd", 32'h00100113, 1'b0, 32'h28, 8'd4);
      out_ready = 1'b1;
      #1;
      checkOutput("resume.ready", 32'(in_ready), 32'd1);
      step();
      checkWord("w2", 32'h00200193, 1'b0, 32'h2C, 8'd4);
      applyStimulus(7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 7'h0, 32'd3);
      step();
      checkWord("w3", 32'h00300213, 1'b0, 32'h30, 8'd4);
      applyStimulus(7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'h0, 32'd4);
      step();
      checkWord("w4", 32'h00400293, 1'b0, 32'h34, 8'd4);
      in_valid = 1'b0;
      step();
      checkOutput("w4drain.valid", 32'(out_valid), 32'd0);
      checkOutput("w4drain.addr", inst_addr, 32'h38);

      // clear has priority over handshakes on both sides in the same cycle
      out_ready = 1'b0;
      applyStimulus(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'h0, 32'd1);
      step();
      checkWord("preClear", 32'h00100113, 1'b0, 32'h38, 8'd4);
      out_ready = 1'b1;
      applyStimulus(7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2);
      clear = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      checkOutput("clear.valid", 32'(out_valid), 32'd0);
      checkOutput("clear.code", inst_code, 32'h0);
      checkOutput("clear.addr", inst_addr, 32'h0);
      checkOutput("clear.cnt", 32'(err_cnt), 32'd0);
      checkOutput("clear.wrapAddr", instAddr2, 32'hFFFFFFFC);

      // Asynchronous reset while a word is held drops it at once
      out_ready = 1'b0;
      applyStimulus(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'h0, 32'd1);
      step();
      in_valid = 1'b0;
      checkWord("preRst", 32'h00100113, 1'b0, 32'h0, 8'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRst.valid", 32'(out_valid), 32'd0);
      checkOutput("asyncRst.code", inst_code, 32'h0);
      #3;
      rst_n = 1'b1;
      step();
      checkOutput("postRst.valid", 32'(out_valid), 32'd0);
      checkOutput("postRst.addr", inst_addr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
